// File: rtl/rgf_stat_cnt_pkg.sv
// Register map constants and CTRL layout shared by the statistics counter block.
package rgf_stat_cnt_pkg;

  localparam int unsigned OVF_STAT_OFFSET = 'h38;
  localparam int unsigned CTRL_OFFSET     = 'h3C;

  localparam int unsigned CTRL_FREEZE_BIT    = 0;
  localparam int unsigned CTRL_CLR_ON_RD_BIT = 1;
  localparam int unsigned CTRL_CLR_ALL_BIT   = 2;

  // Field order mirrors the bit positions above so the struct reads back directly.
  typedef struct packed {
    logic clr_all;
    logic clr_on_rd;
    logic freeze;
  } ctrl_reg_t;

endpackage

// File: rtl/stat_cnt_cell.sv
// One counter channel: load, clear, increment with saturate/wrap, sticky overflow.
// Single-cycle update; no backpressure, every request is absorbed on the next edge.
module stat_cnt_cell #(
  parameter int CNT_WIDTH = 32,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_all,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 rd_clr,
  input  logic                 inc,
  input  logic                 ovf_clr,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 ovf
);

  logic                 at_max;
  logic                 ovf_set;
  logic [CNT_WIDTH-1:0] inc_val;

  assign at_max = &cnt;

  always_comb begin
    inc_val = cnt + CNT_WIDTH'(1);
    if (at_max) begin
      inc_val = SATURATE ? cnt : '0;
    end
  end

  // Only an increment that actually lands can overflow; a load or read-clear swallows it.
  assign ovf_set = inc & ~load & ~rd_clr & at_max;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr_all) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (load) begin
        cnt <= load_val;
      end else if (rd_clr) begin
        cnt <= inc ? CNT_WIDTH'(1) : '0;
      end else if (inc) begin
        cnt <= inc_val;
      end
      ovf <= ovf_set | (ovf & ~ovf_clr);
    end
  end

endmodule

// File: rtl/rgf_stat_cnt.sv
// Bus-mapped bank of statistics counters with freeze, clear-on-read and clear-all control.
// Writes take effect on the next edge, rdata is combinational; no backpressure.
module rgf_stat_cnt
  import rgf_stat_cnt_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CNT    = 8,
  parameter int CNT_WIDTH  = 32,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_WIDTH-1:0]         addr,
  input  logic                          wr_en,
  input  logic                          rd_en,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic                          addr_decoder_leg,
  output logic [DATA_WIDTH-1:0]         rdata,
  input  logic [NUM_CNT-1:0]            inc,
  output logic [NUM_CNT*CNT_WIDTH-1:0]  hw_cnt,
  output logic [NUM_CNT-1:0]            hw_ovf
);

  localparam logic [ADDR_WIDTH-1:0] OVF_ADDR  = ADDR_WIDTH'(OVF_STAT_OFFSET);
  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR = ADDR_WIDTH'(CTRL_OFFSET);

  ctrl_reg_t            ctrl_q;
  logic                 bus_wr;
  logic                 bus_rd;
  logic                 ctrl_wr;
  logic                 ovf_wr;
  logic                 clr_all;
  logic [CNT_WIDTH-1:0] cnt_arr [NUM_CNT];

  assign bus_wr  = wr_en & addr_decoder_leg;
  assign bus_rd  = rd_en & addr_decoder_leg;
  assign ctrl_wr = bus_wr & (addr == CTRL_ADDR);
  assign ovf_wr  = bus_wr & (addr == OVF_ADDR);
  assign clr_all = ctrl_wr & wdata[CTRL_CLR_ALL_BIT];

  // clr_all is a pulse acted on combinationally; its stored bit stays 0 so it reads back 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q <= '0;
    end else if (ctrl_wr) begin
      ctrl_q.freeze    <= wdata[CTRL_FREEZE_BIT];
      ctrl_q.clr_on_rd <= wdata[CTRL_CLR_ON_RD_BIT];
      ctrl_q.clr_all   <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_ch
    localparam logic [ADDR_WIDTH-1:0] CH_ADDR = ADDR_WIDTH'(4 * i);
    logic hit;

    assign hit = (addr == CH_ADDR);

    stat_cnt_cell #(
      .CNT_WIDTH (CNT_WIDTH),
      .SATURATE  (SATURATE)
    ) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_all  (clr_all),
      .load     (bus_wr & hit),
      .load_val (wdata[CNT_WIDTH-1:0]),
      .rd_clr   (bus_rd & ctrl_q.clr_on_rd & hit),
      .inc      (inc[i] & ~ctrl_q.freeze),
      .ovf_clr  (ovf_wr & wdata[i]),
      .cnt      (cnt_arr[i]),
      .ovf      (hw_ovf[i])
    );

    assign hw_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_arr[i];
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (addr == ADDR_WIDTH'(4 * i)) begin
        rdata = DATA_WIDTH'(cnt_arr[i]);
      end
    end
    if (addr == OVF_ADDR) begin
      rdata = DATA_WIDTH'(hw_ovf);
    end
    if (addr == CTRL_ADDR) begin
      rdata = DATA_WIDTH'(ctrl_q);
    end
  end

endmodule

// File: tb/tb_rgf_stat_cnt.sv
// Scoreboard bench: a saturating 32-bit instance and a wrapping 8-bit instance share stimulus.
module tb_rgf_stat_cnt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  addr = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] wdata = '0;
  logic        addr_decoder_leg = 1'b0;
  logic [7:0]  inc = '0;

  logic [31:0]  rdata_a;
  logic [255:0] hw_cnt_a;
  logic [7:0]   hw_ovf_a;
  logic [31:0]  rdata_b;
  logic [63:0]  hw_cnt_b;
  logic [7:0]   hw_ovf_b;

  always #5 clk = ~clk;

  rgf_stat_cnt #(
    .ADDR_WIDTH(6), .DATA_WIDTH(32), .NUM_CNT(8), .CNT_WIDTH(32), .SATURATE(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
    .wdata(wdata), .addr_decoder_leg(addr_decoder_leg), .rdata(rdata_a),
    .inc(inc), .hw_cnt(hw_cnt_a), .hw_ovf(hw_ovf_a)
  );

  rgf_stat_cnt #(
    .ADDR_WIDTH(6), .DATA_WIDTH(32), .NUM_CNT(8), .CNT_WIDTH(8), .SATURATE(1'b0)
  ) dut_wrap (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
    .wdata(wdata), .addr_decoder_leg(addr_decoder_leg), .rdata(rdata_b),
    .inc(inc), .hw_cnt(hw_cnt_b), .hw_ovf(hw_ovf_b)
  );

  // Reference model: index 0 = 32-bit saturating, index 1 = 8-bit wrapping.
  longint unsigned mcnt [2][8];
  bit              movf [2][8];
  bit              m_freeze;
  bit              m_cor;

  typedef struct {
    logic [255:0] ca;
    logic [63:0]  cb;
    logic [7:0]   oa;
    logic [7:0]   ob;
  } st_t;

  st_t         st_q [$];
  logic [63:0] rd_q [$];

  int checks = 0;
  int failures = 0;

  function automatic int wid(int k);
    return (k == 0) ? 32 : 8;
  endfunction

  function automatic logic [31:0] exp_rd(int k, logic [5:0] a);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 8; i++)
      if (a == 6'(4 * i)) v = 32'(mcnt[k][i]);
    if (a == 6'h38)
      for (int i = 0; i < 8; i++) v[i] = movf[k][i];
    if (a == 6'h3C) v = {30'b0, m_cor, m_freeze};
    return v;
  endfunction

  task automatic model_step(input bit r, input bit w, input bit rd, input logic [5:0] a,
                            input logic [31:0] d, input logic [7:0] iv);
    bit              clrall;
    bit              hit;
    bit              up;
    longint unsigned mx;
    if (!r) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 8; i++) begin
          mcnt[k][i] = 0;
          movf[k][i] = 0;
        end
      m_freeze = 0;
      m_cor = 0;
      return;
    end
    clrall = w && (a == 6'h3C) && d[2];
    for (int k = 0; k < 2; k++) begin
      mx = (64'd1 << wid(k)) - 1;
      for (int i = 0; i < 8; i++) begin
        hit = (a == 6'(4 * i));
        up  = iv[i] && !m_freeze;
        if (clrall) begin
          mcnt[k][i] = 0;
          movf[k][i] = 0;
        end else begin
          if (w && a == 6'h38 && d[i]) movf[k][i] = 0;
          if (w && hit) mcnt[k][i] = longint'(d) & mx;
          else if (rd && m_cor && hit) mcnt[k][i] = up ? 1 : 0;
          else if (up) begin
            if (mcnt[k][i] == mx) begin
              movf[k][i] = 1;
              mcnt[k][i] = (k == 0) ? mx : 0;
            end else begin
              mcnt[k][i] = mcnt[k][i] + 1;
            end
          end
        end
      end
    end
    if (w && a == 6'h3C) begin
      m_freeze = d[0];
      m_cor    = d[1];
    end
  endtask

  task automatic cycle(input bit r, input bit s, input bit w, input bit rd,
                       input logic [5:0] a, input logic [31:0] d, input logic [7:0] iv);
    st_t st;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      st.ca[i*32 +: 32] = mcnt[0][i][31:0];
      st.cb[i*8 +: 8]   = mcnt[1][i][7:0];
      st.oa[i]          = movf[0][i];
      st.ob[i]          = movf[1][i];
    end
    st_q.push_back(st);
    rst_n = r;
    addr_decoder_leg = s;
    wr_en = w;
    rd_en = rd;
    addr = a;
    wdata = d;
    inc = iv;
    if (s && rd) rd_q.push_back({exp_rd(0, a), exp_rd(1, a)});
    model_step(r, s && w, s && rd, a, d, iv);
  endtask

  task automatic bus(input bit w, input bit rd, input logic [5:0] a,
                     input logic [31:0] d, input logic [7:0] iv);
    cycle(1'b1, 1'b1, w, rd, a, d, iv);
  endtask

  always @(negedge clk) begin
    st_t         st;
    logic [63:0] e;
    if (st_q.size() > 0) begin
      st = st_q.pop_front();
      checks += 4;
      if (hw_cnt_a !== st.ca) begin
        failures++;
        $display("FAIL hw_cnt_sat t=%0t got=%h exp=%h", $time, hw_cnt_a, st.ca);
      end
      if (hw_cnt_b !== st.cb) begin
        failures++;
        $display("FAIL hw_cnt_wrap t=%0t got=%h exp=%h", $time, hw_cnt_b, st.cb);
      end
      if (hw_ovf_a !== st.oa) begin
        failures++;
        $display("FAIL hw_ovf_sat t=%0t got=%h exp=%h", $time, hw_ovf_a, st.oa);
      end
      if (hw_ovf_b !== st.ob) begin
        failures++;
        $display("FAIL hw_ovf_wrap t=%0t got=%h exp=%h", $time, hw_ovf_b, st.ob);
      end
    end
    if (addr_decoder_leg && rd_en) begin
      checks++;
      if (rd_q.size() == 0) begin
        failures++;
        $display("FAIL rd_underflow t=%0t addr=%h no expected read queued", $time, addr);
      end else begin
        e = rd_q.pop_front();
        checks++;
        if (rdata_a !== e[63:32]) begin
          failures++;
          $display("FAIL rdata_sat t=%0t addr=%h got=%h exp=%h", $time, addr, rdata_a, e[63:32]);
        end
        if (rdata_b !== e[31:0]) begin
          failures++;
          $display("FAIL rdata_wrap t=%0t addr=%h got=%h exp=%h", $time, addr, rdata_b, e[31:0]);
        end
      end
    end
  end

  initial begin
    bit          r, s, w, rd;
    logic [5:0]  a;
    logic [31:0] d;
    logic [7:0]  iv;

    cycle(1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 32'h0, 8'h00);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 6'h00, 32'h1234, 8'hFF);

    // Basic increment on channel 0
    repeat (5) bus(1'b0, 1'b0, 6'h00, 32'h0, 8'h01);
    bus(1'b0, 1'b1, 6'h00, 32'h0, 8'h00);

    // Saturation and W1C on channel 1
    bus(1'b1, 1'b0, 6'h04, 32'hFFFF_FFFE, 8'h00);
    repeat (3) bus(1'b0, 1'b0, 6'h00, 32'h0, 8'h02);
    bus(1'b0, 1'b1, 6'h04, 32'h0, 8'h00);
    bus(1'b0, 1'b1, 6'h38, 32'h0, 8'h00);
    bus(1'b1, 1'b1, 6'h38, 32'h2, 8'h00);
    bus(1'b0, 1'b1, 6'h38, 32'h0, 8'h00);

    // Wrap on channel 2 (8-bit instance), overflow racing a W1C
    bus(1'b1, 1'b0, 6'h08, 32'hFF, 8'h00);
    bus(1'b0, 1'b1, 6'h08, 32'h0, 8'h04);
    bus(1'b0, 1'b1, 6'h38, 32'h0, 8'h00);
    bus(1'b1, 1'b0, 6'h08, 32'hFFFF_FFFF, 8'h00);
    bus(1'b1, 1'b0, 6'h38, 32'h4, 8'h04);
    bus(1'b0, 1'b1, 6'h38, 32'h0, 8'h00);

    // Clear-on-read colliding with an increment
    bus(1'b1, 1'b0, 6'h3C, 32'h2, 8'h00);
    bus(1'b1, 1'b0, 6'h0C, 32'h7, 8'h00);
    bus(1'b0, 1'b1, 6'h0C, 32'h0, 8'h08);
    bus(1'b0, 1'b1, 6'h3C, 32'h0, 8'h00);
    bus(1'b1, 1'b0, 6'h10, 32'h55, 8'h10);
    bus(1'b1, 1'b1, 6'h3C, 32'h0, 8'h00);

    // Freeze, then clear-all
    bus(1'b1, 1'b0, 6'h3C, 32'h1, 8'h00);
    repeat (10) bus(1'b0, 1'b0, 6'h00, 32'h0, 8'hFF);
    bus(1'b0, 1'b1, 6'h00, 32'h0, 8'h00);
    bus(1'b1, 1'b0, 6'h3C, 32'h4, 8'hFF);
    bus(1'b0, 1'b1, 6'h38, 32'h0, 8'h00);
    bus(1'b0, 1'b1, 6'h3C, 32'h0, 8'h00);

    // Unselected strobes and unmapped offsets
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 6'h04, 32'hDEAD_BEEF, 8'h00);
    bus(1'b1, 1'b1, 6'h24, 32'hDEAD_BEEF, 8'h00);
    bus(1'b0, 1'b1, 6'h3E, 32'h0, 8'h00);

    // Reset asserted during a write with increments active
    repeat (3) bus(1'b0, 1'b0, 6'h00, 32'h0, 8'hFF);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 6'h00, 32'h5, 8'hFF);
    bus(1'b0, 1'b1, 6'h00, 32'h0, 8'h00);

    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 99) != 0);
      s  = ($urandom_range(0, 9) != 0);
      w  = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = 6'(4 * $urandom_range(0, 7));
        6:       a = 6'h38;
        7:       a = 6'h3C;
        default: a = 6'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       d = 32'hFFFF_FFFF;
        1:       d = 32'hFFFF_FFFE;
        2:       d = 32'h0000_00FE;
        default: d = $urandom;
      endcase
      if (a == 6'h3C) d = 32'($urandom_range(0, 3)) | (($urandom_range(0, 15) == 0) ? 32'h4 : 32'h0);
      iv = 8'($urandom);
      cycle(r, s, w, rd, a, d, iv);
    end

    bus(1'b0, 1'b0, 6'h00, 32'h0, 8'h00);
    bus(1'b0, 1'b0, 6'h00, 32'h0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rd_q.size() != 0) begin
      failures++;
      $display("FAIL rd_drain leftover=%0d exp=0", rd_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rgf_stat_cnt.md
RGF_STAT_CNT -- requirements
Module: rgf_stat_cnt

Interface
REQ-001 Parameter ADDR_WIDTH, default 6: byte-address width of the bus interface.
REQ-002 Parameter DATA_WIDTH, default 32: bus data width.
REQ-003 Parameter NUM_CNT, default 8: number of counter channels, legal 1..14.
REQ-004 Parameter CNT_WIDTH, default 32: counter width, legal 1..DATA_WIDTH.
REQ-005 Parameter SATURATE, default 1: 1 = counters saturate at max; 0 = counters wrap to 0.
REQ-006 Port clk, input, 1: single clock; all logic is on its rising edge.
REQ-007 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-008 Port addr, input, ADDR_WIDTH: byte address.
REQ-009 Port wr_en, input, 1: write strobe.
REQ-010 Port rd_en, input, 1: read strobe.
REQ-011 Port wdata, input, DATA_WIDTH: write data.
REQ-012 Port addr_decoder_leg, input, 1: block select; wr_en and rd_en act only when it is 1.
REQ-013 Port rdata, output, DATA_WIDTH: read data, combinational from addr.
REQ-014 Port inc, input, NUM_CNT: per-channel increment request, one count per cycle while high.
REQ-015 Port hw_cnt, output, NUM_CNT*CNT_WIDTH: packed counter values; channel i occupies bits [i*CNT_WIDTH +: CNT_WIDTH].
REQ-016 Port hw_ovf, output, NUM_CNT: sticky per-channel overflow flags.

Function
REQ-017 Address map SHALL be: counter i at 4*i; OVF_STAT at 'h38; CTRL at 'h3C. Any other offset reads 0 and ignores writes.
REQ-018 CTRL SHALL contain: bit0 FREEZE (rw), bit1 CLR_ON_RD (rw), bit2 CLR_ALL (write-1 pulse, reads 0). All other bits read 0.
REQ-019 A read of counter i SHALL return the value zero-extended to DATA_WIDTH. Reads of OVF_STAT SHALL return hw_ovf in bits [NUM_CNT-1:0].
REQ-020 A write to counter i SHALL load wdata[CNT_WIDTH-1:0] on the next edge.
REQ-021 A write to OVF_STAT SHALL clear each flag whose wdata bit is 1 (write-1-to-clear).
REQ-022 When inc[i]=1 and FREEZE=0, counter i SHALL add 1 on the next edge. Increments SHALL be ignored while FREEZE=1; bus access is unaffected by FREEZE.
REQ-023 An increment at all-ones SHALL set hw_ovf[i] and leave the counter at all-ones when SATURATE=1, or set it to 0 when SATURATE=0.
REQ-024 When CLR_ON_RD=1, a qualified read of counter i SHALL return the pre-clear value and clear the counter on the same edge.
REQ-025 A write of 1 to CTRL bit2 SHALL clear all counters and all hw_ovf flags on the next edge. The FREEZE and CLR_ON_RD fields are updated by the same write.
REQ-026 Per-channel priority SHALL be: CLR_ALL, then bus write to the counter, then clear-on-read, then increment.
    - Bus write with inc in the same cycle: the write wins and the increment is lost.
    - Clear-on-read with inc: the counter becomes 1.
REQ-027 Overflow and a W1C to the same flag in the same cycle SHALL leave the flag set.
REQ-028 wr_en and rd_en both high in one cycle SHALL perform both operations; rdata SHALL show the pre-write value.

Reset
REQ-029 While rst_n=0 at a clock edge:
    - all counters, hw_ovf, FREEZE and CLR_ON_RD SHALL become 0;
    - hw_cnt SHALL then be 0;
    - inc and bus strobes SHALL be ignored.
REQ-030 Reset asserted mid-operation SHALL override every pending write, clear or increment in that cycle.

Structure
REQ-031 Package rgf_stat_cnt_pkg SHALL hold the OVF_STAT and CTRL offsets, the CTRL bit positions, and the packed typedef ctrl_reg_t.
REQ-032 Sub-module stat_cnt_cell SHALL implement one channel (load, clear, increment, saturate/wrap, overflow). It is instantiated NUM_CNT times in a generate loop.

Verification
REQ-033 Increment: after reset, inc[0]=1 for 5 cycles -> read 'h00 returns 5 and hw_cnt[31:0]=5.
REQ-034 Saturate: with SATURATE=1, write 'h04 = 'hFFFFFFFE, then inc[1] for 3 cycles -> counter 'hFFFFFFFF, hw_ovf[1]=1. Write 'h38 = 'h2 -> hw_ovf=0.
REQ-035 Wrap: with SATURATE=0 and CNT_WIDTH=8, write 'hFF to channel 2, then 1 inc -> value 0, hw_ovf[2]=1.
REQ-036 Clear-on-read: CTRL='h2, counter 3 = 7, read 'h0C with inc[3]=1 in the same cycle -> rdata=7, next value 1.
REQ-037 Freeze and clear: CTRL='h1 with inc all-ones for 10 cycles -> counters unchanged. Write CTRL='h4 -> all counters 0 and hw_ovf 0.
REQ-038 Reset mid-operation: rst_n=0 during a write with inc active -> all outputs 0 on the next edge.
